// File: rtl/digit_unloader_if.sv
// Digit serializer bus: word capture request in, digit stream out on valid/ready.
interface digit_unloader_if #(
  parameter int unsigned COUNT = 4,
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned WORD_W = COUNT * WIDTH;
  localparam int unsigned IDX_W  = (COUNT > 1) ? $clog2(COUNT) : 1;

  logic              load;
  logic              dir;
  logic [WORD_W-1:0] word_in;
  logic [WIDTH-1:0]  digit_out;
  logic              digit_valid;
  logic              digit_ready;
  logic [IDX_W-1:0]  digit_idx;
  logic              last;
  logic              busy;
  logic              done;

  // Producer of words and consumer of digits
  modport master (
    output load, dir, word_in, digit_ready,
    input  digit_out, digit_valid, digit_idx, last, busy, done
  );

  // The serializer itself
  modport slave (
    input  load, dir, word_in, digit_ready,
    output digit_out, digit_valid, digit_idx, last, busy, done
  );
endinterface

// File: rtl/digit_unloader.sv
// Parallel-to-digit serializer: captures a COUNT*WIDTH word and emits it one
// digit per accepted handshake, MSB-first (dir=0) or LSB-first (dir=1).
module digit_unloader #(
  parameter int unsigned COUNT = 4,
  parameter int unsigned WIDTH = 4
) (
  input logic             clk,
  input logic             reset,
  digit_unloader_if.slave bus
);
  localparam int unsigned WORD_W = COUNT * WIDTH;
  localparam int unsigned IDX_W  = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              dir_q,   dir_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic              done_q,  done_d;

  logic              xfer;
  logic              is_last;

  // Handshake fires only while a digit is actually being presented
  assign xfer    = (state_q == SEND) && bus.digit_ready;
  assign is_last = (idx_q == LAST_IDX);

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      dir_q   <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      dir_q   <= dir_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Next-state: capture in IDLE, shift toward the emitting end on each transfer
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    dir_d   = dir_q;
    idx_d   = idx_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.load) begin
          shreg_d = bus.word_in;
          dir_d   = bus.dir;
          idx_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        if (xfer) begin
          if (is_last) begin
            state_d = IDLE;
            shreg_d = '0;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            shreg_d = dir_q ? (shreg_q >> WIDTH) : (shreg_q << WIDTH);
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        shreg_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs decoded from registered state only; no path from ready/load
  always_comb begin
    bus.busy        = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit_out   = '0;
    bus.digit_idx   = idx_q;
    bus.last        = 1'b0;
    bus.done        = done_q;

    if (state_q == SEND) begin
      bus.busy        = 1'b1;
      bus.digit_valid = 1'b1;
      bus.last        = is_last;
      bus.digit_out   = dir_q ? shreg_q[WIDTH-1:0] : shreg_q[WORD_W-1 -: WIDTH];
    end
  end
endmodule
